// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared FSM encoding, reset PC default and alignment helper
package fetch_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ALIGN_MASK;
  endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: redirect, instruction-memory and decode-side signals of the fetch unit
interface fetch_ctrl_if;
  logic        i_flush_sig;
  logic [31:0] i_flush_data;
  logic        i_branch_sig;
  logic [31:0] i_branch_data;
  logic        i_stall;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  modport master (
    input  i_flush_sig, i_flush_data, i_branch_sig, i_branch_data, i_stall,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_mem_req, o_mem_addr, o_inst_valid, o_inst, o_inst_pc
  );
  modport slave (
    output i_flush_sig, i_flush_data, i_branch_sig, i_branch_data, i_stall,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_mem_req, o_mem_addr, o_inst_valid, o_inst, o_inst_pc
  );
endinterface

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: priority select of the next word-aligned pc (flush > branch > pc+4)
module fetch_next_pc
  import fetch_ctrl_pkg::*;
(
  input  logic        flush_i,
  input  logic [31:0] flush_data_i,
  input  logic        branch_i,
  input  logic [31:0] branch_data_i,
  input  logic [31:0] pc_i,
  output logic [31:0] next_pc_o
);
  // Redirect targets win over sequential increment; low address bits are dropped
  always_comb begin
    next_pc_o = align_pc(flush_i ? flush_data_i : branch_i ? branch_data_i : pc_i + 32'd4);
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch FSM with redirect and decode stall
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input logic          i_clk,
  input logic          i_rst,
  fetch_ctrl_if.master bus
);
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, next_pc;
  logic        discard_q, discard_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic        redirect, mem_req, grant, rvalid, capture;

  assign redirect = bus.i_flush_sig || bus.i_branch_sig;
  assign grant    = mem_req && bus.i_mem_gnt;
  assign rvalid   = state_q == WAIT && bus.i_mem_rvalid;
  assign capture  = rvalid && !discard_q && !redirect;

  fetch_next_pc u_next_pc (
    .flush_i       (bus.i_flush_sig),
    .flush_data_i  (bus.i_flush_data),
    .branch_i      (bus.i_branch_sig),
    .branch_data_i (bus.i_branch_data),
    .pc_i          (pc_q),
    .next_pc_o     (next_pc)
  );

  // State register; reset abandons any outstanding request
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: leave IDLE at once, wait for grant, then for the single response
  always_comb begin
    state_d = state_q == REQ  ? (grant ? WAIT : REQ) :
              state_q == WAIT ? (bus.i_mem_rvalid ? REQ : WAIT) : REQ;
  end

  // Outputs: request only when the output slot is free or draining this cycle
  always_comb begin
    mem_req          = state_q == REQ && (!valid_q || !bus.i_stall);
    bus.o_mem_req    = mem_req;
    bus.o_mem_addr   = pc_q;
    bus.o_inst_valid = valid_q;
    bus.o_inst       = inst_q;
    bus.o_inst_pc    = ipc_q;
  end

  // Datapath next values: redirect kills the slot and marks an in-flight response stale
  always_comb begin
    pc_d      = (redirect || capture) ? next_pc : pc_q;
    discard_d = state_q == REQ  ? (discard_q || (redirect && grant)) :
                state_q == WAIT ? (!bus.i_mem_rvalid && (discard_q || redirect)) : discard_q;
    valid_d   = redirect ? 1'b0 : capture ? 1'b1 : valid_q && bus.i_stall;
    inst_d    = capture ? bus.i_mem_rdata : inst_q;
    ipc_d     = capture ? pc_q : ipc_q;
  end

  // Datapath registers; pc is kept word aligned at all times
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q      <= align_pc(RESET_PC);
      discard_q <= 1'b0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      ipc_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      ipc_q     <= ipc_d;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of fetch_ctrl sequencing, stall, redirect, wrap and reset
module tb_fetch_ctrl;
  logic clk, rst;
  int   n_assert, n_fail;

  fetch_ctrl_if bus();

  fetch_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic resp(input logic [31:0] d);
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = d;
    tick();
    bus.i_mem_rvalid = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.i_flush_sig   = 1'b0;
    bus.i_flush_data  = '0;
    bus.i_branch_sig  = 1'b0;
    bus.i_branch_data = '0;
    bus.i_stall       = 1'b0;
    bus.i_mem_gnt     = 1'b0;
    bus.i_mem_rvalid  = 1'b0;
    bus.i_mem_rdata   = '0;
    tick();
    tick();
    chk1("rst_req", bus.o_mem_req, 1'b0);
    chk1("rst_valid", bus.o_inst_valid, 1'b0);
    chk("rst_inst", bus.o_inst, 32'h0);
    chk("rst_inst_pc", bus.o_inst_pc, 32'h0);
    rst = 1'b0;
    bus.i_mem_gnt = 1'b1;
    tick();
    chk1("c1_req", bus.o_mem_req, 1'b1);
    chk("c1_addr", bus.o_mem_addr, 32'h0);
    chk1("c1_valid", bus.o_inst_valid, 1'b0);
    tick();
    chk1("c2_wait_req", bus.o_mem_req, 1'b0);
    resp(32'h1111_0000);
    chk1("c3_valid", bus.o_inst_valid, 1'b1);
    chk("c3_inst", bus.o_inst, 32'h1111_0000);
    chk("c3_pc", bus.o_inst_pc, 32'h0);
    chk("c3_addr", bus.o_mem_addr, 32'h4);
    chk1("c3_req", bus.o_mem_req, 1'b1);
    tick();
    chk1("c4_valid", bus.o_inst_valid, 1'b0);
    resp(32'h2222_0004);
    chk1("c5_valid", bus.o_inst_valid, 1'b1);
    chk("c5_pc", bus.o_inst_pc, 32'h4);
    chk("c5_addr", bus.o_mem_addr, 32'h8);
    tick();
    resp(32'h3333_0008);
    chk1("c7_valid", bus.o_inst_valid, 1'b1);
    chk("c7_inst", bus.o_inst, 32'h3333_0008);
    chk("c7_pc", bus.o_inst_pc, 32'h8);
    bus.i_stall = 1'b1;
    #1;
    chk1("stall_req", bus.o_mem_req, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("stall_valid", bus.o_inst_valid, 1'b1);
      chk("stall_inst", bus.o_inst, 32'h3333_0008);
      chk("stall_pc", bus.o_inst_pc, 32'h8);
      chk1("stall_req_hold", bus.o_mem_req, 1'b0);
    end
    bus.i_stall = 1'b0;
    #1;
    chk1("unstall_req", bus.o_mem_req, 1'b1);
    chk("unstall_addr", bus.o_mem_addr, 32'hC);
    tick();
    chk1("unstall_valid_clr", bus.o_inst_valid, 1'b0);
    bus.i_branch_sig  = 1'b1;
    bus.i_branch_data = 32'h100;
    tick();
    bus.i_branch_sig = 1'b0;
    chk1("br_wait_req", bus.o_mem_req, 1'b0);
    tick();
    resp(32'hDEAD_BEEF);
    chk1("br_drop_valid", bus.o_inst_valid, 1'b0);
    chk1("br_req", bus.o_mem_req, 1'b1);
    chk("br_addr", bus.o_mem_addr, 32'h100);
    tick();
    resp(32'hA0A0_0100);
    chk1("br_fetch_valid", bus.o_inst_valid, 1'b1);
    chk("br_fetch_inst", bus.o_inst, 32'hA0A0_0100);
    chk("br_fetch_pc", bus.o_inst_pc, 32'h100);
    chk("br_next_addr", bus.o_mem_addr, 32'h104);
    bus.i_mem_gnt     = 1'b0;
    bus.i_flush_sig   = 1'b1;
    bus.i_flush_data  = 32'h200;
    bus.i_branch_sig  = 1'b1;
    bus.i_branch_data = 32'h300;
    tick();
    bus.i_flush_sig  = 1'b0;
    bus.i_branch_sig = 1'b0;
    chk("prio_addr", bus.o_mem_addr, 32'h200);
    chk1("prio_valid", bus.o_inst_valid, 1'b0);
    chk1("prio_req", bus.o_mem_req, 1'b1);
    bus.i_mem_gnt     = 1'b1;
    bus.i_branch_sig  = 1'b1;
    bus.i_branch_data = 32'h400;
    tick();
    bus.i_branch_sig = 1'b0;
    chk1("gntredir_wait_req", bus.o_mem_req, 1'b0);
    resp(32'h5555_5555);
    chk1("gntredir_drop_valid", bus.o_inst_valid, 1'b0);
    chk("gntredir_addr", bus.o_mem_addr, 32'h400);
    bus.i_mem_gnt    = 1'b0;
    bus.i_flush_sig  = 1'b1;
    bus.i_flush_data = 32'hFFFF_FFFF;
    tick();
    bus.i_flush_sig = 1'b0;
    chk("wrap_addr", bus.o_mem_addr, 32'hFFFF_FFFC);
    bus.i_mem_gnt = 1'b1;
    tick();
    resp(32'hC0DE_FFFC);
    chk1("wrap_valid", bus.o_inst_valid, 1'b1);
    chk("wrap_pc", bus.o_inst_pc, 32'hFFFF_FFFC);
    chk("wrap_next_addr", bus.o_mem_addr, 32'h0);
    tick();
    resp(32'h1234_0000);
    chk("pre_rst_addr", bus.o_mem_addr, 32'h4);
    tick();
    rst = 1'b1;
    #1;
    chk1("mid_rst_req", bus.o_mem_req, 1'b0);
    chk1("mid_rst_valid", bus.o_inst_valid, 1'b0);
    chk("mid_rst_inst", bus.o_inst, 32'h0);
    tick();
    rst = 1'b0;
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'hBAD0_BAD0;
    tick();
    bus.i_mem_rvalid = 1'b0;
    chk1("late_rvalid_valid", bus.o_inst_valid, 1'b0);
    chk1("post_rst_req", bus.o_mem_req, 1'b1);
    chk("post_rst_addr", bus.o_mem_addr, 32'h0);
    tick();
    chk1("post_rst_valid2", bus.o_inst_valid, 1'b0);
    chk("post_rst_addr2", bus.o_mem_addr, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
